// File: rtl/tlul_monitor.sv
// Passive TL-UL link monitor: outstanding table, counters,
// worst-case latency and sticky protocol flags.
package tlul_pkg;
  parameter int TL_AW  = 32;
  parameter int TL_DW  = 32;
  parameter int TL_AIW = 8;
  parameter int TL_DIW = 1;
  parameter int TL_DBW = TL_DW / 8;
  parameter int TL_SZW = 2;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_monitor
  import tlul_pkg::*;
#(
  parameter int Depth       = 4,
  parameter int CntW        = 16,
  parameter int LatW        = 12,
  parameter bit CheckStable = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  tl_h2d_t                    tl_i,
  input  tl_d2h_t                    tl_o,
  input  logic                       clear_i,
  output logic [CntW-1:0]            rd_cnt_o,
  output logic [CntW-1:0]            wr_cnt_o,
  output logic [CntW-1:0]            err_cnt_o,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic [LatW-1:0]            max_lat_o,
  output logic [4:0]                 violation_o
);
  localparam int OW = $clog2(Depth + 1);
  localparam int PW = 6 + TL_SZW + TL_AIW
                    + TL_AW + TL_DBW + TL_DW;

  logic [Depth-1:0]             ent_valid;
  logic [Depth-1:0][TL_AIW-1:0] ent_src;
  logic [Depth-1:0]             ent_get;
  logic [Depth-1:0][LatW-1:0]   ent_ts;

  logic [LatW-1:0] now;
  logic [PW-1:0]   snap_q;
  logic            stall_q;

  logic a_fire, d_fire, is_get, is_put;
  logic found, d_hit, hit_get, dup, full, got;
  logic [Depth-1:0] hit_oh, kept, alloc_oh;
  logic [LatW-1:0]  hit_ts, lat;
  logic [PW-1:0]    payload;
  logic [4:0]       viol_set;

  assign a_fire  = tl_i.a_valid & tl_o.a_ready;
  assign d_fire  = tl_o.d_valid & tl_i.d_ready;
  assign is_get  = tl_i.a_opcode == Get;
  assign is_put  = tl_i.a_opcode == PutFullData
                 | tl_i.a_opcode == PutPartialData;
  assign payload = {tl_i.a_opcode, tl_i.a_param,
                    tl_i.a_size, tl_i.a_source,
                    tl_i.a_address, tl_i.a_mask,
                    tl_i.a_data};

  // D lookup on pre-edge entries, then A allocation on what remains
  always_comb begin
    hit_oh   = '0;
    hit_get  = 1'b0;
    hit_ts   = '0;
    found    = 1'b0;
    dup      = 1'b0;
    alloc_oh = '0;
    got      = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (!found && ent_valid[i] &&
          ent_src[i] == tl_o.d_source) begin
        found     = 1'b1;
        hit_oh[i] = 1'b1;
        hit_get   = ent_get[i];
        hit_ts    = ent_ts[i];
      end
    end
    d_hit = d_fire & found;
    kept  = ent_valid & ~(d_fire ? hit_oh : '0);
    for (int i = 0; i < Depth; i++) begin
      if (kept[i] && ent_src[i] == tl_i.a_source)
        dup = 1'b1;
      if (!got && !kept[i]) begin
        alloc_oh[i] = 1'b1;
        got         = 1'b1;
      end
    end
    full = &kept;
    lat  = now - hit_ts;
  end

  // Protocol flags raised this cycle
  always_comb begin
    viol_set    = '0;
    viol_set[0] = CheckStable && stall_q &&
                  (!tl_i.a_valid || payload != snap_q);
    viol_set[1] = a_fire & dup;
    viol_set[2] = d_fire & ~found;
    viol_set[3] = a_fire & full;
    viol_set[4] = d_hit & (hit_get ?
                  tl_o.d_opcode != AccessAckData :
                  tl_o.d_opcode != AccessAck);
  end

  // Occupied entry count
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < Depth; i++)
      outstanding_o = outstanding_o + OW'(ent_valid[i]);
  end

  // Outstanding table: retire on D hit, fill on A fire
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent_valid <= '0;
      ent_src   <= '0;
      ent_get   <= '0;
      ent_ts    <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (a_fire && alloc_oh[i]) begin
          ent_src[i] <= tl_i.a_source;
          ent_get[i] <= is_get;
          ent_ts[i]  <= now;
        end
      end
      ent_valid <= kept | (a_fire ? alloc_oh : '0);
    end
  end

  // Timestamp base and A-channel stability snapshot
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      now     <= '0;
      snap_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      now     <= now + 1'b1;
      snap_q  <= payload;
      stall_q <= tl_i.a_valid & ~tl_o.a_ready;
    end
  end

  // Saturating counters, max latency, sticky flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rd_cnt_o    <= '0;
      wr_cnt_o    <= '0;
      err_cnt_o   <= '0;
      max_lat_o   <= '0;
      violation_o <= '0;
    end else begin
      if (a_fire && is_get && rd_cnt_o != '1)
        rd_cnt_o <= rd_cnt_o + 1'b1;
      if (a_fire && is_put && wr_cnt_o != '1)
        wr_cnt_o <= wr_cnt_o + 1'b1;
      if (d_fire && tl_o.d_error && err_cnt_o != '1)
        err_cnt_o <= err_cnt_o + 1'b1;
      if (d_hit && lat > max_lat_o)
        max_lat_o <= lat;
      violation_o <= violation_o | viol_set;
    end
  end

  logic unused_d;
  assign unused_d = ^{tl_o.d_param, tl_o.d_size,
                      tl_o.d_sink, tl_o.d_data};
endmodule

// File: tb/tb_tlul_monitor.sv
// Bench for tlul_monitor: directed table, corner sequences,
// and random traffic against a transaction-level model.
module tb_tlul_monitor;
  import tlul_pkg::*;

  localparam int DEPTH = 4;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    clear;
  tl_h2d_t h2d;
  tl_d2h_t d2h;

  logic [15:0] rd_a, wr_a, er_a;
  logic [1:0]  rd_b, wr_b, er_b;
  logic [2:0]  os_a, os_b;
  logic [11:0] lat_a, lat_b;
  logic [4:0]  v_a, v_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tlul_monitor u_a (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(h2d), .tl_o(d2h),
    .clear_i(clear), .rd_cnt_o(rd_a), .wr_cnt_o(wr_a),
    .err_cnt_o(er_a), .outstanding_o(os_a),
    .max_lat_o(lat_a), .violation_o(v_a)
  );

  tlul_monitor #(.CntW(2), .CheckStable(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(h2d), .tl_o(d2h),
    .clear_i(clear), .rd_cnt_o(rd_b), .wr_cnt_o(wr_b),
    .err_cnt_o(er_b), .outstanding_o(os_b),
    .max_lat_o(lat_b), .violation_o(v_b)
  );

  // ---------------- reference model ----------------
  int       m_rd, m_wr, m_er, m_lat, cyc;
  logic [4:0] m_v;
  bit       mv[DEPTH];
  logic [7:0] msrc[DEPTH];
  bit       mget[DEPTH];
  int       mts[DEPTH];
  tl_h2d_t  m_prev;
  bit       m_stall;

  bit af, df, hit, dup, full, placed, chg;
  int hi, lt;
  logic [4:0] set;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rd = 0; m_wr = 0; m_er = 0; m_lat = 0;
      m_v = '0; cyc = 0; m_stall = 0; m_prev = '0;
      for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    end else begin
      af = h2d.a_valid && d2h.a_ready;
      df = d2h.d_valid && h2d.d_ready;
      set = '0;
      chg = m_prev.a_opcode != h2d.a_opcode ||
            m_prev.a_param != h2d.a_param ||
            m_prev.a_size != h2d.a_size ||
            m_prev.a_source != h2d.a_source ||
            m_prev.a_address != h2d.a_address ||
            m_prev.a_mask != h2d.a_mask ||
            m_prev.a_data != h2d.a_data;
      if (m_stall && (!h2d.a_valid || chg)) set[0] = 1;
      hit = 0; hi = 0; lt = 0;
      if (df)
        for (int i = 0; i < DEPTH; i++)
          if (!hit && mv[i] && msrc[i] == d2h.d_source) begin
            hit = 1; hi = i;
          end
      if (df && !hit) set[2] = 1;
      if (hit) begin
        lt = (cyc - mts[hi]) % 4096;
        set[4] = mget[hi] ? d2h.d_opcode != AccessAckData
                          : d2h.d_opcode != AccessAck;
        mv[hi] = 0;
      end
      if (af) begin
        dup = 0; full = 1; placed = 0;
        for (int i = 0; i < DEPTH; i++) begin
          if (mv[i] && msrc[i] == h2d.a_source) dup = 1;
          if (!mv[i]) full = 0;
        end
        set[1] = dup;
        set[3] = full;
        for (int i = 0; i < DEPTH; i++)
          if (!placed && !mv[i]) begin
            placed = 1; mv[i] = 1;
            msrc[i] = h2d.a_source;
            mget[i] = h2d.a_opcode == Get;
            mts[i] = cyc;
          end
      end
      if (clear) begin
        m_rd = 0; m_wr = 0; m_er = 0; m_lat = 0; m_v = '0;
      end else begin
        if (af && h2d.a_opcode == Get) m_rd++;
        if (af && (h2d.a_opcode == PutFullData ||
                   h2d.a_opcode == PutPartialData)) m_wr++;
        if (df && d2h.d_error) m_er++;
        if (hit && lt > m_lat) m_lat = lt;
        m_v = m_v | set;
      end
      m_prev = h2d;
      m_stall = h2d.a_valid && !d2h.a_ready;
      cyc++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic longint sat(int v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : longint'(v);
  endfunction

  function automatic int m_os();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
    return n;
  endfunction

  task automatic check_model();
    chk("m_rd_a", rd_a, sat(m_rd, 16));
    chk("m_wr_a", wr_a, sat(m_wr, 16));
    chk("m_er_a", er_a, sat(m_er, 16));
    chk("m_os_a", os_a, m_os());
    chk("m_lat_a", lat_a, m_lat);
    chk("m_v_a", v_a, m_v);
    chk("m_rd_b", rd_b, sat(m_rd, 2));
    chk("m_wr_b", wr_b, sat(m_wr, 2));
    chk("m_er_b", er_b, sat(m_er, 2));
    chk("m_os_b", os_b, m_os());
    chk("m_lat_b", lat_b, m_lat);
    chk("m_v_b", v_b, {m_v[4:1], 1'b0});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    h2d = '0;
    d2h = '0;
    h2d.d_ready = 1'b1;
    d2h.a_ready = 1'b1;
    clear = 1'b0;
  endtask

  task automatic put_a(logic [2:0] op, logic [7:0] src);
    h2d.a_valid = 1'b1;
    h2d.a_opcode = op;
    h2d.a_source = src;
  endtask

  task automatic put_d(logic [2:0] op, logic [7:0] src);
    d2h.d_valid = 1'b1;
    d2h.d_opcode = op;
    d2h.d_source = src;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic av, ar; logic [2:0] aop; logic [7:0] asrc;
    logic [31:0] aadr;
    logic dv; logic [2:0] dop; logic [7:0] dsrc;
    logic derr, clr;
    int rd, wr, er, os, lat; logic [4:0] v;
  } vec_t;

  vec_t tv[27];

  function automatic vec_t mk(
    logic av, logic ar, logic [2:0] aop, logic [7:0] asrc,
    logic [31:0] aadr, logic dv, logic [2:0] dop,
    logic [7:0] dsrc, logic derr, logic clr,
    int rd, int wr, int er, int os, int lat, logic [4:0] v);
    vec_t t;
    t.av = av; t.ar = ar; t.aop = aop; t.asrc = asrc;
    t.aadr = aadr; t.dv = dv; t.dop = dop; t.dsrc = dsrc;
    t.derr = derr; t.clr = clr; t.rd = rd; t.wr = wr;
    t.er = er; t.os = os; t.lat = lat; t.v = v;
    return t;
  endfunction

  localparam logic [2:0] PF = PutFullData;
  localparam logic [2:0] GT = Get;
  localparam logic [2:0] AA = AccessAck;
  localparam logic [2:0] AD = AccessAckData;

  initial begin
    tv[0]  = mk(1,1,GT,3,32'h10, 0,AA,0,0,0, 1,0,0,1,0,5'h00);
    for (int i = 1; i < 5; i++)
      tv[i] = mk(0,1,GT,0,0, 0,AA,0,0,0, 1,0,0,1,0,5'h00);
    tv[5]  = mk(0,1,GT,0,0, 1,AD,3,0,0, 1,0,0,0,5,5'h00);
    tv[6]  = mk(1,1,PF,0,0, 0,AA,0,0,0, 1,1,0,1,5,5'h00);
    tv[7]  = mk(1,1,PF,1,0, 0,AA,0,0,0, 1,2,0,2,5,5'h00);
    tv[8]  = mk(1,1,PF,2,0, 0,AA,0,0,0, 1,3,0,3,5,5'h00);
    tv[9]  = mk(1,1,PF,3,0, 0,AA,0,0,0, 1,4,0,4,5,5'h00);
    tv[10] = mk(1,1,PF,4,0, 0,AA,0,0,0, 1,5,0,4,5,5'h08);
    tv[11] = mk(0,1,GT,0,0, 1,AA,0,0,0, 1,5,0,3,5,5'h08);
    tv[12] = mk(0,1,GT,0,0, 1,AA,7,1,0, 1,5,1,3,5,5'h0c);
    tv[13] = mk(0,1,GT,0,0, 1,AA,1,0,0, 1,5,1,2,6,5'h0c);
    tv[14] = mk(0,1,GT,0,0, 1,AA,2,0,0, 1,5,1,1,6,5'h0c);
    tv[15] = mk(0,1,GT,0,0, 1,AA,3,0,0, 1,5,1,0,6,5'h0c);
    tv[16] = mk(1,1,GT,2,0, 0,AA,0,0,0, 2,5,1,1,6,5'h0c);
    tv[17] = mk(0,1,GT,0,0, 1,AA,2,0,0, 2,5,1,0,6,5'h1c);
    tv[18] = mk(0,1,GT,0,0, 0,AA,0,0,1, 0,0,0,0,0,5'h00);
    tv[19] = mk(1,0,GT,5,0, 0,AA,0,0,0, 0,0,0,0,0,5'h00);
    tv[20] = mk(1,0,GT,5,4, 0,AA,0,0,0, 0,0,0,0,0,5'h01);
    tv[21] = mk(0,1,GT,0,0, 0,AA,0,0,0, 0,0,0,0,0,5'h01);
    tv[22] = mk(0,1,GT,0,0, 0,AA,0,0,1, 0,0,0,0,0,5'h00);
    tv[23] = mk(1,1,GT,6,0, 0,AA,0,0,1, 0,0,0,1,0,5'h00);
    tv[24] = mk(0,1,GT,0,0, 1,AD,6,0,0, 0,0,0,0,1,5'h00);
    tv[25] = mk(1,1,GT,8,0, 1,AD,8,0,0, 1,0,0,1,1,5'h04);
    tv[26] = mk(0,1,GT,0,0, 1,AD,8,0,0, 1,0,0,0,1,5'h04);
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_rd", rd_a, 0);
    chk("rst_v", v_a, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 27; r++) begin
      idle();
      h2d.a_valid   = tv[r].av;
      d2h.a_ready   = tv[r].ar;
      h2d.a_opcode  = tv[r].aop;
      h2d.a_source  = tv[r].asrc;
      h2d.a_address = tv[r].aadr;
      d2h.d_valid   = tv[r].dv;
      d2h.d_opcode  = tv[r].dop;
      d2h.d_source  = tv[r].dsrc;
      d2h.d_error   = tv[r].derr;
      clear         = tv[r].clr;
      step();
      chk($sformatf("row%0d_rd", r), rd_a, tv[r].rd);
      chk($sformatf("row%0d_wr", r), wr_a, tv[r].wr);
      chk($sformatf("row%0d_er", r), er_a, tv[r].er);
      chk($sformatf("row%0d_os", r), os_a, tv[r].os);
      chk($sformatf("row%0d_lat", r), lat_a, tv[r].lat);
      chk($sformatf("row%0d_v", r), v_a, tv[r].v);
      if (r == 20) chk("nostab_b", v_b[0], 0);
    end

    // saturation on the narrow instance
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle();
      put_a(GT, 8'(k));
      step();
      idle();
      put_d(AD, 8'(k));
      step();
    end
    idle();
    chk("sat_rd_b", rd_b, 3);
    chk("sat_rd_a", rd_a, 5);
    chk("sat_v_b", v_b, 0);

    // reset with two entries outstanding
    put_a(GT, 8'd1);
    step();
    idle();
    put_a(GT, 8'd2);
    step();
    idle();
    chk("pre_rst_os", os_a, 2);
    rst_n = 1'b0;
    step();
    chk("rst_os", os_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_rd_b", rd_b, 0);
    chk("rst_lat", lat_a, 0);
    rst_n = 1'b1;
    put_d(AD, 8'd1);
    step();
    idle();
    chk("stale_d_v", v_a, 5'h04);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int i;
      if (!(h2d.a_valid && !d2h.a_ready) ||
          $urandom_range(0, 15) == 0) begin
        h2d.a_valid = $urandom_range(0, 2) != 0;
        case ($urandom_range(0, 2))
          0: h2d.a_opcode = PutFullData;
          1: h2d.a_opcode = PutPartialData;
          default: h2d.a_opcode = Get;
        endcase
        h2d.a_source  = 8'($urandom_range(0, 7));
        h2d.a_address = 32'($urandom_range(0, 15)) << 2;
        h2d.a_mask    = 4'($urandom);
        h2d.a_data    = $urandom;
      end
      d2h.a_ready = $urandom_range(0, 3) != 0;
      h2d.d_ready = $urandom_range(0, 3) != 0;
      d2h.d_valid = $urandom_range(0, 1) == 1;
      d2h.d_error = $urandom_range(0, 7) == 0;
      i = $urandom_range(0, DEPTH - 1);
      if (mv[i] && $urandom_range(0, 7) != 0) begin
        d2h.d_source = msrc[i];
        d2h.d_opcode = mget[i] ? AccessAckData : AccessAck;
        if ($urandom_range(0, 15) == 0)
          d2h.d_opcode = ~d2h.d_opcode & 3'h1;
      end else begin
        d2h.d_source = 8'($urandom_range(0, 9));
        d2h.d_opcode = 3'($urandom_range(0, 1));
      end
      clear = $urandom_range(0, 99) == 0;
      rst_n = $urandom_range(0, 499) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tlul_monitor.md
# tlul_monitor

Passive, parametrised TL-UL bus monitor for the simulation bench. It observes one host/device TL-UL link and tracks outstanding transactions per source ID in a small table. It keeps saturating read/write/error counters, measures worst-case request-to-response latency, and raises sticky protocol-violation flags. It never drives the bus and sits in the testbench beside the DUT's TL-UL port.

## Interface
Parameters:
- Depth, 4: outstanding-table entries (1..16)
- CntW, 16: width of transaction counters
- LatW, 12: width of timestamp/latency counter
- CheckStable, 1: enable A-channel stability check

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low, sampled on rising clk_i
- tl_i  in  tlul_pkg::tl_h2d_t  host-to-device struct (A channel + d_ready)
- tl_o  in  tlul_pkg::tl_d2h_t  device-to-host struct (D channel + a_ready)
- clear_i  in  1  synchronous clear of counters, max latency and violations (table untouched)
- rd_cnt_o  out  CntW  accepted Get requests
- wr_cnt_o  out  CntW  accepted PutFullData/PutPartialData requests
- err_cnt_o  out  CntW  D beats accepted with d_error=1
- outstanding_o  out  $clog2(Depth+1)  occupied table entries
- max_lat_o  out  LatW  largest observed A-fire to D-fire latency, in cycles
- violation_o  out  5  sticky protocol flags, bits defined below

## Operation
- a_fire = a_valid & a_ready. d_fire = d_valid & d_ready.
- Table entry fields: valid, source (TL_AIW), is_get, timestamp (LatW).
- A free-running cycle counter `now` (LatW) wraps modulo 2^LatW.
- On a_fire:
  - Get increments rd_cnt_o. Any Put increments wr_cnt_o.
  - Allocate the lowest-index free entry with {source, is_get, now}.
- On d_fire:
  - CAM match on valid entries by d_source.
  - On a hit: free the entry and compute latency = now − timestamp, modulo 2^LatW.
  - max_lat_o updates when latency exceeds it.
  - d_error=1 increments err_cnt_o, whether the source hits or misses.
- Counters saturate at all-ones. They never wrap.
- Violation bits are sticky until clear_i or reset:
  - [0] A payload (opcode, param, size, source, address, mask, data) changed, or a_valid dropped, while a_valid=1 & a_ready=0 the previous cycle. Only when CheckStable=1.
  - [1] a_fire with an a_source already valid in the table (duplicate ID).
  - [2] d_fire with a d_source that matches no valid entry.
  - [3] a_fire while all Depth entries are valid. The request is not recorded and is still counted.
  - [4] d_fire opcode mismatch: matched is_get needs AccessAckData, otherwise AccessAck.
- Simultaneous a_fire and d_fire in one cycle:
  - D matches only entries valid before the edge, so a same-cycle response to the same-cycle request flags [2].
  - An entry freed by D is reusable by A in the same cycle. Overflow [3] is evaluated after the D retirement.
- clear_i=1 with a fire in the same cycle: the clear wins and the fire's counter and flag effects are dropped. Table allocate and free still happen.

## Timing
- All outputs are registered and reflect a fire one cycle after the clk_i edge on which it occurred.
- Reset value of every output is 0 while rst_ni=0 at a clock edge. Reset clears the table, `now`, and the stability snapshot.
- Reset asserted mid-transaction discards outstanding entries. A D beat arriving after reset for a pre-reset request flags [2].
- Stability snapshot: A payload is registered every cycle. The check compares against the snapshot when the previous cycle had a_valid=1 & a_ready=0.
- Latency: an A fire at cycle t with a D fire at t+k reports k. k = 0 is impossible and flags [2]. k ≥ 2^LatW aliases and is not detected.

## Test plan
- Get at addr 0x10 with source 3, a_ready=1, then AccessAckData 5 cycles later -> rd_cnt_o=1, max_lat_o=5, outstanding_o 1→0, violation_o=0.
- Four PutFullData with sources 0–3 then a fifth with source 4, Depth=4, no responses -> wr_cnt_o=5, outstanding_o=4, violation_o[3]=1.
- Hold a_valid=1 with a_ready=0 and change a_address 0x0→0x4 -> violation_o[0]=1 next cycle. With CheckStable=0 -> stays 0.
- AccessAck with d_source=7 when nothing is outstanding, d_error=1 -> violation_o[2]=1, err_cnt_o=1.
- Get on source 2 answered with AccessAck -> violation_o[4]=1. Then clear_i pulse -> all counters, max_lat_o and violation_o return to 0.
- CntW=2, five Gets with responses -> rd_cnt_o saturates at 3. Assert rst_ni=0 with two entries outstanding -> all outputs 0 one cycle later.
